// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the IF/MEM memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic {
    OWNER_MEM = 1'b0,
    OWNER_IF  = 1'b1
  } owner_e;

  // RESP cycles tolerated before a transaction is closed as a bus error.
  localparam int unsigned TMO_CYC_DEFAULT = 255;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one external memory port between instruction fetch (IF)
// and load/store (MEM). One bus transaction at a time, MEM has priority,
// but IF gets the next turn once it has waited behind a MEM transaction.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no transaction; arbitrate and latch the winner's request
//   REQ     | bus_valid_o high with latched fields until bus_ready_i
//   RESP    | waiting for bus_rvalid_i; timeout counter running
//   DONE    | one cycle: owner un-stalled, data presented, error pulsed
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned TMO_CYC = TMO_CYC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req_i,
  input  logic [ADDR_W-1:0]  if_addr_i,
  input  logic               mem_rd_i,
  input  logic               mem_wr_i,
  input  logic [ADDR_W-1:0]  mem_addr_i,
  input  logic [DATA_W-1:0]  mem_wdata_i,
  input  logic               flush_i,
  output logic               stall_if_o,
  output logic               stall_mem_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [DATA_W-1:0]  rdata_o,
  output logic               idle_if_o,
  output logic               bus_err_o,
  output logic               bus_valid_o,
  input  logic               bus_ready_i,
  output logic               bus_we_o,
  output logic [ADDR_W-1:0]  bus_addr_o,
  output logic [DATA_W-1:0]  bus_wdata_o,
  input  logic               bus_rvalid_i,
  input  logic [DATA_W-1:0]  bus_rdata_i
);

  localparam logic [7:0] TMO_LIM = TMO_CYC[7:0];

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  owner_e              last_owner_q, last_owner_d;
  logic                drop_q, drop_d;
  logic                if_wait_q, if_wait_d;
  logic [7:0]          tmo_cnt_q, tmo_cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                bus_valid_q, bus_valid_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic                bus_err_q, bus_err_d;

  logic mem_req;
  logic grant_if;

  assign mem_req = mem_rd_i | mem_wr_i;

  // State register: every flop of the arbiter, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWNER_MEM;
      last_owner_q <= OWNER_MEM;
      drop_q       <= 1'b0;
      if_wait_q    <= 1'b0;
      tmo_cnt_q    <= '0;
      data_q       <= '0;
      bus_valid_q  <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      drop_q       <= drop_d;
      if_wait_q    <= if_wait_d;
      tmo_cnt_q    <= tmo_cnt_d;
      data_q       <= data_d;
      bus_valid_q  <= bus_valid_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_err_q    <= bus_err_d;
    end
  end

  // Next-state logic: arbitration, bus handshake, timeout and flush tracking.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    drop_d       = drop_q;
    tmo_cnt_d    = tmo_cnt_q;
    data_d       = data_q;
    bus_valid_d  = bus_valid_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_err_d    = 1'b0;
    // IF only overrides MEM after it sat through a MEM transaction.
    grant_if     = if_req_i & (~mem_req | ((last_owner_q == OWNER_MEM) & if_wait_q));

    case (state_q)
      ST_IDLE: begin
        tmo_cnt_d = '0;
        drop_d    = 1'b0;
        if (if_req_i | mem_req) begin
          state_d     = ST_REQ;
          bus_valid_d = 1'b1;
          owner_d     = grant_if ? OWNER_IF : OWNER_MEM;
          bus_we_d    = grant_if ? 1'b0 : mem_wr_i;
          bus_addr_d  = grant_if ? if_addr_i : mem_addr_i;
          bus_wdata_d = grant_if ? '0 : mem_wdata_i;
        end
      end
      ST_REQ: begin
        if (bus_ready_i) begin
          state_d     = ST_RESP;
          bus_valid_d = 1'b0;
        end
      end
      ST_RESP: begin
        if (bus_rvalid_i) begin
          data_d  = bus_rdata_i;
          state_d = ST_DONE;
        end else if (tmo_cnt_q == TMO_LIM) begin
          data_d    = '0;
          bus_err_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        state_d      = ST_IDLE;
        last_owner_d = owner_q;
        drop_d       = 1'b0;
        tmo_cnt_d    = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    // A redirect while our fetch is on the bus: let it finish, discard result.
    if (flush_i && (owner_q == OWNER_IF) && ((state_q == ST_REQ) || (state_q == ST_RESP)))
      drop_d = 1'b1;

    // IF is "waiting" while it holds a request through a MEM transaction.
    if (state_q == ST_IDLE)
      if_wait_d = 1'b0;
    else
      if_wait_d = if_req_i & (if_wait_q | (owner_q == OWNER_MEM));
  end

  // Outputs: stalls from state and live requests, everything else from flops.
  always_comb begin
    stall_if_o  = if_req_i & ~((state_q == ST_DONE) & (owner_q == OWNER_IF) & ~drop_q);
    stall_mem_o = mem_req & ~((state_q == ST_DONE) & (owner_q == OWNER_MEM));
    idle_if_o   = ~((state_q != ST_IDLE) & (owner_q == OWNER_IF));
  end

  assign instr_o     = data_q[INSTR_W-1:0];
  assign rdata_o     = data_q;
  assign bus_err_o   = bus_err_q;
  assign bus_valid_o = bus_valid_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;

endmodule
